// File: rtl/cpu_pkg.sv
// Shared CPU definitions: op2 select encoding, opcode/funct values and
// issue-controller state type.
package cpu_pkg;

  typedef enum logic [1:0] {
    SRC_RT   = 2'b00,
    SRC_SA   = 2'b01,
    SRC_SIMM = 2'b10,
    SRC_ZIMM = 2'b11
  } alusrc_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } issue_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;

endpackage

// File: rtl/op2_fwd_unit.sv
// Combinational rt forwarding mux (EX over MEM over register file) and
// load-use hazard detection for the op2 path.
module op2_fwd_unit
  import cpu_pkg::*;
(
  input  logic        id_valid,
  input  logic        uses_rt,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rt_data,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_reg,
  input  logic [31:0] ex_wr_data,
  input  logic        ex_is_load,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wr_reg,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] fwd_data,
  output logic        hazard
);

  logic rt_nz;
  logic ex_hit;
  logic mem_hit;

  assign rt_nz   = (id_rt != 5'd0);
  assign ex_hit  = rt_nz && ex_wr_en && (ex_wr_reg == id_rt);
  assign mem_hit = rt_nz && mem_wr_en && (mem_wr_reg == id_rt);

  // A load in EX has no data yet, so it must not shadow an older MEM result.
  always_comb begin
    fwd_data = id_rt_data;
    if (ex_hit && !ex_is_load) begin
      fwd_data = ex_wr_data;
    end else if (mem_hit) begin
      fwd_data = mem_wr_data;
    end
  end

  assign hazard = id_valid && uses_rt && ex_hit && ex_is_load;

endmodule

// File: rtl/op2_issue_ctrl.sv
// Execute-stage op2 issue controller: decodes the op2 select, forwards rt,
// inserts load-use bubbles and registers the operand bundle under valid/ready.
module op2_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [5:0]             id_opcode,
  input  logic [5:0]             id_funct,
  input  logic [4:0]             id_rt,
  input  logic [31:0]            id_rt_data,
  input  logic [4:0]             id_sa,
  input  logic [15:0]            id_imm,
  input  logic                   ex_wr_en,
  input  logic [4:0]             ex_wr_reg,
  input  logic [31:0]            ex_wr_data,
  input  logic                   ex_is_load,
  input  logic                   mem_wr_en,
  input  logic [4:0]             mem_wr_reg,
  input  logic [31:0]            mem_wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             ALUSrcs,
  output logic [31:0]            op2_sub,
  output logic [4:0]             sa,
  output logic [15:0]            immediate,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  alusrc_t      dec_src_p0;
  logic         uses_rt_p0;
  logic [31:0]  fwd_data_p0;
  logic         hazard_p0;
  issue_state_t state;
  logic         adv;
  logic         xfer;

  function automatic alusrc_t decode_src(input logic [5:0] opcode,
                                         input logic [5:0] funct);
    alusrc_t src;
    src = SRC_RT;
    if (opcode == OP_RTYPE) begin
      if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
        src = SRC_SA;
      end
    end else if (opcode inside {[OP_ADDI:OP_SLTIU], [OP_LB:OP_LHU], [OP_SB:OP_SW]}) begin
      src = SRC_SIMM;
    end else if (opcode inside {[OP_ANDI:OP_LUI]}) begin
      src = SRC_ZIMM;
    end
    return src;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // ---- stage p0: decode, forward, hazard (combinational on ID inputs)
  assign dec_src_p0 = decode_src(id_opcode, id_funct);
  assign uses_rt_p0 = (dec_src_p0 == SRC_RT) && (id_rt != 5'd0);

  op2_fwd_unit u_fwd (
    .id_valid    (id_valid),
    .uses_rt     (uses_rt_p0),
    .id_rt       (id_rt),
    .id_rt_data  (id_rt_data),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_reg   (ex_wr_reg),
    .ex_wr_data  (ex_wr_data),
    .ex_is_load  (ex_is_load),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_reg  (mem_wr_reg),
    .mem_wr_data (mem_wr_data),
    .fwd_data    (fwd_data_p0),
    .hazard      (hazard_p0)
  );

  assign adv      = !out_valid || out_ready;
  assign id_ready = adv && (state == RUN) && !hazard_p0;
  assign xfer     = id_valid && id_ready;

  // ---- stage p1: ID/EX operand bundle and issue FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUSrcs   <= 2'b00;
      op2_sub   <= 32'd0;
      sa        <= 5'd0;
      immediate <= 16'd0;
      stall_cnt <= '0;
      state     <= RUN;
    end else if (adv) begin
      out_valid <= xfer;
      if (xfer) begin
        ALUSrcs   <= dec_src_p0;
        op2_sub   <= fwd_data_p0;
        sa        <= id_sa;
        immediate <= id_imm;
      end
      // STALL always releases after one advancing cycle; the instruction is
      // then re-evaluated in RUN against the updated EX/MEM state.
      if (state == STALL) begin
        state <= RUN;
      end else if (hazard_p0) begin
        state     <= STALL;
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_op2_issue_ctrl.sv
// Randomized and directed bench for op2_issue_ctrl against an in-bench
// behavioural model of the issue rules.
module tb_op2_issue_ctrl;

  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic          id_ready;
  logic [5:0]    id_opcode;
  logic [5:0]    id_funct;
  logic [4:0]    id_rt;
  logic [31:0]   id_rt_data;
  logic [4:0]    id_sa;
  logic [15:0]   id_imm;
  logic          ex_wr_en;
  logic [4:0]    ex_wr_reg;
  logic [31:0]   ex_wr_data;
  logic          ex_is_load;
  logic          mem_wr_en;
  logic [4:0]    mem_wr_reg;
  logic [31:0]   mem_wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    ALUSrcs;
  logic [31:0]   op2_sub;
  logic [4:0]    sa;
  logic [15:0]   immediate;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic        m_valid;
  logic [1:0]  m_src;
  logic [31:0] m_op2;
  logic [4:0]  m_sa;
  logic [15:0] m_imm;
  int          m_cnt;
  int          m_stall_left;

  op2_issue_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rt(id_rt), .id_rt_data(id_rt_data),
    .id_sa(id_sa), .id_imm(id_imm),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data),
    .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUSrcs(ALUSrcs), .op2_sub(op2_sub), .sa(sa), .immediate(immediate),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_src(input int op, input int fn);
    if (op == 0) return (fn == 0 || fn == 2 || fn == 3) ? 2'd1 : 2'd0;
    if ((op >= 8 && op <= 11) || (op >= 32 && op <= 37) || (op >= 40 && op <= 43)) return 2'd2;
    if (op >= 12 && op <= 15) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_fwd();
    if (id_rt == 0) return id_rt_data;
    if (ex_wr_en && ex_wr_reg == id_rt && !ex_is_load) return ex_wr_data;
    if (mem_wr_en && mem_wr_reg == id_rt) return mem_wr_data;
    return id_rt_data;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_src = 2'd0; m_op2 = 32'd0; m_sa = 5'd0; m_imm = 16'd0;
    m_cnt = 0; m_stall_left = 0;
  endtask

  task automatic check_regs();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("ALUSrcs", {30'd0, ALUSrcs}, {30'd0, m_src});
    check("op2_sub", op2_sub, m_op2);
    check("sa", {27'd0, sa}, {27'd0, m_sa});
    check("immediate", {16'd0, immediate}, {16'd0, m_imm});
    check("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, m_cnt);
  endtask

  // Called right after a negedge with inputs already driven; advances one clock.
  task automatic cycle();
    logic adv, hz, rdy, take;
    logic [1:0] src;
    #1;
    src  = ref_src(id_opcode, id_funct);
    adv  = !m_valid || out_ready;
    hz   = id_valid && src == 2'd0 && id_rt != 0 && ex_wr_en && ex_is_load && ex_wr_reg == id_rt;
    rdy  = adv && m_stall_left == 0 && !hz;
    take = id_valid && rdy;
    check("id_ready", {31'd0, id_ready}, {31'd0, rdy});
    if (adv) begin
      m_valid = take;
      if (take) begin
        m_src = src; m_op2 = ref_fwd(); m_sa = id_sa; m_imm = id_imm;
      end
      if (m_stall_left > 0) m_stall_left = 0;
      else if (hz) begin
        m_stall_left = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_opcode = 0; id_funct = 0; id_rt = 0; id_rt_data = 0;
    id_sa = 0; id_imm = 0; ex_wr_en = 0; ex_wr_reg = 0; ex_wr_data = 0;
    ex_is_load = 0; mem_wr_en = 0; mem_wr_reg = 0; mem_wr_data = 0; out_ready = 1;
  endtask

  task automatic set_add(input logic [4:0] rt, input logic [31:0] rtd);
    id_valid = 1; id_opcode = 6'h00; id_funct = 6'h20; id_rt = rt; id_rt_data = rtd;
  endtask

  initial begin
    int ops[20] = '{0, 0, 0, 0, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 32, 35, 37, 40, 43, 63};
    int fns[5]  = '{0, 2, 3, 32, 8};
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check_regs();
    check("reset stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);

    cycle();
    // ori imm 0x8001
    id_valid = 1; id_opcode = 6'h0D; id_imm = 16'h8001;
    cycle();
    check("ori valid", {31'd0, out_valid}, 32'd1);
    check("ori src", {30'd0, ALUSrcs}, 32'd3);
    check("ori imm", {16'd0, immediate}, 32'h8001);
    // sll sa=7
    id_opcode = 6'h00; id_funct = 6'h00; id_sa = 5'd7;
    cycle();
    check("sll src", {30'd0, ALUSrcs}, 32'd1);
    check("sll sa", {27'd0, sa}, 32'd7);
    // addi
    id_opcode = 6'h08;
    cycle();
    check("addi src", {30'd0, ALUSrcs}, 32'd2);
    // forwarding
    set_add(5'd5, 32'h11);
    ex_wr_en = 1; ex_wr_reg = 5; ex_wr_data = 32'hAAAA; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_reg = 5; mem_wr_data = 32'hBBBB;
    cycle();
    check("fwd ex", op2_sub, 32'hAAAA);
    ex_wr_en = 0;
    cycle();
    check("fwd mem", op2_sub, 32'hBBBB);
    id_rt = 0;
    cycle();
    check("fwd rt0", op2_sub, 32'h11);
    // load-use
    set_add(5'd5, 32'h11);
    ex_wr_en = 1; ex_wr_reg = 5; ex_is_load = 1; mem_wr_en = 0;
    cycle();
    check("lu bubble", {31'd0, out_valid}, 32'd0);
    check("lu count", {{(32-CW){1'b0}}, stall_cnt}, 32'd1);
    ex_wr_en = 0; ex_is_load = 0; mem_wr_en = 1; mem_wr_reg = 5; mem_wr_data = 32'hCAFE;
    cycle();
    check("lu stall bubble", {31'd0, out_valid}, 32'd0);
    cycle();
    check("lu accept valid", {31'd0, out_valid}, 32'd1);
    check("lu accept data", op2_sub, 32'hCAFE);
    // backpressure
    out_ready = 0;
    id_opcode = 6'h0D; id_imm = 16'h1234;
    repeat (3) begin
      cycle();
      check("bp hold data", op2_sub, 32'hCAFE);
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1;
    cycle();
    check("bp release imm", {16'd0, immediate}, 32'h1234);
    // reset during STALL
    set_add(5'd5, 32'h11);
    ex_wr_en = 1; ex_wr_reg = 5; ex_is_load = 1;
    cycle();
    #2 rst = 1;
    #1;
    check("async rst valid", {31'd0, out_valid}, 32'd0);
    check("async rst count", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    id_valid = 1; id_opcode = 6'h0D; id_imm = 16'h0042;
    cycle();
    check("post rst accept", {31'd0, out_valid}, 32'd1);
    check("post rst src", {30'd0, ALUSrcs}, 32'd3);
    // saturation: persistent hazard re-enters STALL every other cycle
    set_add(5'd3, 32'h0);
    ex_wr_en = 1; ex_wr_reg = 3; ex_is_load = 1;
    repeat (20) cycle();
    check("sat count", {{(32-CW){1'b0}}, stall_cnt}, CNT_MAX);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      id_valid    = ($urandom_range(0, 9) < 7);
      id_opcode   = 6'(ops[$urandom_range(0, 19)]);
      id_funct    = 6'(fns[$urandom_range(0, 4)]);
      id_rt       = 5'($urandom_range(0, 3));
      id_rt_data  = $urandom;
      id_sa       = 5'($urandom);
      id_imm      = 16'($urandom);
      ex_wr_en    = $urandom_range(0, 1) == 1;
      ex_wr_reg   = 5'($urandom_range(0, 3));
      ex_wr_data  = $urandom;
      ex_is_load  = ($urandom_range(0, 9) < 3);
      mem_wr_en   = $urandom_range(0, 1) == 1;
      mem_wr_reg  = 5'($urandom_range(0, 3));
      mem_wr_data = $urandom;
      out_ready   = ($urandom_range(0, 9) < 7);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
